// File: rtl/core_pkg.sv
// Shared core widths, AXI response codes and the fetch queue entry layout.
package core_pkg;
   localparam int REG_WIDTH  = 32;
   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef struct packed {
      logic [REG_WIDTH-1:0] pc;
      logic [REG_WIDTH-1:0] instr;
      logic                 err;
   } fetch_entry_t;
endpackage

// File: rtl/core_fetch_queue.sv
// Synchronous FIFO of fetched instructions; pointers carry an extra wrap bit
// so full and empty are distinguishable without a separate counter.
module core_fetch_queue
   import core_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  fetch_entry_t           i_data,
   output fetch_entry_t           o_head,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_empty,
   output logic                   o_full
);
   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W:0]   r_wr_ptr;
   logic [PTR_W:0]   r_rd_ptr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: the head is only consumed while the queue is non-empty.
   always_ff @(posedge i_clk) begin
      if (i_push && !i_flush) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
   end

   assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
   assign o_count = r_wr_ptr - r_rd_ptr;
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
endmodule

// File: rtl/core_fetch_prefetch.sv
// Prefetching fetch stage: AXI-lite read master with bounded outstanding reads,
// an instruction queue toward decode, and branch flush with stale-response drop.
module core_fetch_prefetch
   import core_pkg::*;
#(
   parameter int                   FIFO_DEPTH      = 4,
   parameter int                   MAX_OUTSTANDING = 2,
   parameter logic [REG_WIDTH-1:0] RESET_PC        = 32'h0000_0000,
   parameter logic [REG_WIDTH-1:0] NOP_INSTR       = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_stall,
   input  logic                  is_branch,
   input  logic [REG_WIDTH-1:0]  new_pc,
   output logic [REG_WIDTH-1:0]  instr,
   output logic [REG_WIDTH-1:0]  instr_pc,
   output logic                  instr_valid,
   output logic                  instr_err,
   output logic [ADDR_WIDTH-1:0] ARADDR,
   output logic                  ARVALID,
   input  logic                  ARREADY,
   input  logic [DATA_WIDTH-1:0] RDATA,
   input  logic [1:0]            RRESP,
   input  logic                  RVALID,
   output logic                  RREADY
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [REG_WIDTH-1:0]  r_fetch_pc;
   logic [REG_WIDTH-1:0]  r_resp_pc;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic                  r_arvalid;
   logic [CNT_W-1:0]      r_outstanding;
   logic [CNT_W-1:0]      r_drop_cnt;

   logic                  w_ar_hs;
   logic                  w_r_hs;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_issue;
   logic [CNT_W-1:0]      w_out_next;
   logic [CNT_W-1:0]      w_cnt_next;
   logic [CNT_W:0]        w_reserve;
   logic [CNT_W-1:0]      w_drop_next;
   logic [REG_WIDTH-1:0]  w_pc_base;
   fetch_entry_t          w_push_entry;
   fetch_entry_t          w_head;
   logic [CNT_W-1:0]      w_q_count;
   logic                  w_q_empty;
   logic                  w_q_full;

   // Every in-flight read owns a queue slot, so R can always be accepted.
   assign RREADY  = 1'b1;
   assign ARVALID = r_arvalid;
   assign ARADDR  = r_araddr;

   assign w_ar_hs = r_arvalid & ARREADY;
   assign w_r_hs  = RVALID & RREADY;
   assign w_push  = w_r_hs & (r_drop_cnt == '0) & ~is_branch;
   assign w_pop   = ~w_q_empty & ~fetch_stall & ~is_branch;

   assign w_out_next = r_outstanding + CNT_W'(w_ar_hs) - CNT_W'(w_r_hs);
   assign w_cnt_next = is_branch ? '0 : (w_q_count + CNT_W'(w_push) - CNT_W'(w_pop));
   assign w_reserve  = {1'b0, w_out_next} + {1'b0, w_cnt_next};

   // A new address is raised only when the bus is free and a slot is reserved for it.
   assign w_issue = (~r_arvalid | ARREADY) &
                    (w_out_next < CNT_W'(MAX_OUTSTANDING)) &
                    (w_reserve <= (CNT_W+1)'(FIFO_DEPTH - 1));

   // r_fetch_pc is the next address not yet placed on AR, so a pending AR keeps its old address.
   assign w_pc_base = is_branch ? (new_pc & ~REG_WIDTH'(3)) : r_fetch_pc;

   always_comb begin
      w_drop_next = r_drop_cnt;
      if (is_branch)
         w_drop_next = w_out_next + CNT_W'(r_arvalid & ~ARREADY);
      else if (w_r_hs && (r_drop_cnt != '0))
         w_drop_next = r_drop_cnt - 1'b1;
   end

   assign w_push_entry = '{pc: r_resp_pc, instr: RDATA, err: (RRESP != AXI_RESP_OKAY)};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_araddr      <= RESET_PC;
         r_arvalid     <= 1'b0;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_outstanding <= w_out_next;
         r_drop_cnt    <= w_drop_next;
         if (w_issue) begin
            r_arvalid  <= 1'b1;
            r_araddr   <= w_pc_base;
            r_fetch_pc <= w_pc_base + REG_WIDTH'(4);
         end else begin
            if (w_ar_hs) r_arvalid <= 1'b0;
            r_fetch_pc <= w_pc_base;
         end
         if (is_branch)   r_resp_pc <= new_pc & ~REG_WIDTH'(3);
         else if (w_push) r_resp_pc <= r_resp_pc + REG_WIDTH'(4);
      end
   end

   core_fetch_queue #(
      .DEPTH (FIFO_DEPTH)
   ) u_queue (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_flush (is_branch),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_push_entry),
      .o_head  (w_head),
      .o_count (w_q_count),
      .o_empty (w_q_empty),
      .o_full  (w_q_full)
   );

   assign instr_valid = ~w_q_empty;
   assign instr       = w_q_empty ? NOP_INSTR : w_head.instr;
   assign instr_pc    = w_q_empty ? '0 : w_head.pc;
   assign instr_err   = ~w_q_empty & w_head.err;

   a_outstanding: assert property (@(posedge clk) disable iff (!rst)
      r_outstanding <= CNT_W'(MAX_OUTSTANDING));
   a_count: assert property (@(posedge clk) disable iff (!rst)
      w_q_count <= CNT_W'(FIFO_DEPTH));
   a_push_full: assert property (@(posedge clk) disable iff (!rst)
      !(w_push && w_q_full));
endmodule

// File: tb/tb_core_fetch_prefetch.sv
// Directed bench for core_fetch_prefetch: a small AXI-lite memory responder
// returning address-as-data, and an in-order scoreboard of retired instructions.
module tb_core_fetch_prefetch;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_stall;
   logic        is_branch;
   logic [31:0] new_pc;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_err;
   logic [31:0] ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;

   core_fetch_prefetch dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_stall (fetch_stall),
      .is_branch   (is_branch),
      .new_pc      (new_pc),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_err   (instr_err),
      .ARADDR      (ARADDR),
      .ARVALID     (ARVALID),
      .ARREADY     (ARREADY),
      .RDATA       (RDATA),
      .RRESP       (RRESP),
      .RVALID      (RVALID),
      .RREADY      (RREADY)
   );

   always #5 clk = ~clk;

   int          vectors;
   int          miscompares;
   int          cyc;
   logic [32:0] exp_q[$];
   logic [31:0] rsp_addr_q[$];
   int          rsp_due_q[$];
   int          lat;
   int          ar_delay;
   int          ar_wait;
   int          tb_out;
   int          ar_total;
   logic        err_en;
   logic [31:0] err_addr;
   logic        hold_v;
   logic [31:0] hold_a;
   logic        stab_en;
   logic [31:0] ar_exp;
   int          ar_chk_n;
   int          ar_skip;
   int          br_mode;
   logic [31:0] br_target;
   logic [31:0] br_expect;
   logic        br_done;
   logic        gap_en;
   int          last_ret;

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive responder and strobes for the coming posedge, score, advance to next negedge.
   task automatic tick();
      logic        hs;
      logic        rhs;
      logic [32:0] e;
      if (stab_en && hold_v) begin
         check_vec("arvalid_hold", {31'b0, ARVALID}, 32'd1);
         check_vec("araddr_hold", ARADDR, hold_a);
      end
      ARREADY = ARVALID && (ar_wait >= ar_delay);
      hs      = ARVALID && ARREADY;
      hold_v  = ARVALID && !ARREADY;
      hold_a  = ARADDR;
      rhs     = 1'b0;
      if (rsp_addr_q.size() > 0 && rsp_due_q[0] <= cyc) begin
         RVALID = 1'b1;
         RDATA  = rsp_addr_q[0];
         RRESP  = (err_en && rsp_addr_q[0] == err_addr) ? 2'b10 : 2'b00;
         rhs    = 1'b1;
         rsp_addr_q.delete(0);
         rsp_due_q.delete(0);
      end else begin
         RVALID = 1'b0;
         RDATA  = '0;
         RRESP  = '0;
      end
      if (hs) begin
         rsp_addr_q.push_back(ARADDR);
         rsp_due_q.push_back(cyc + lat);
         ar_total++;
      end
      ar_wait = hs ? 0 : (ARVALID ? ar_wait + 1 : 0);
      is_branch = 1'b0;
      if ((br_mode == 1 && tb_out == 2) || (br_mode == 2 && RVALID && ARVALID && !ARREADY)) begin
         is_branch = 1'b1;
         new_pc    = br_target;
         br_mode   = 0;
         br_done   = 1'b1;
      end
      if (is_branch) begin
         ar_skip  = hold_v ? 1 : 0;
         ar_exp   = br_expect;
         ar_chk_n = 1;
      end else if (hs) begin
         if (ar_skip > 0) ar_skip--;
         else if (ar_chk_n > 0) begin
            check_vec("araddr", ARADDR, ar_exp);
            ar_exp = ar_exp + 32'd4;
            ar_chk_n--;
         end
      end
      if (stab_en) check_vec("outstanding_le2", {31'b0, (tb_out <= 2)}, 32'd1);
      tb_out = tb_out + int'(hs) - int'(rhs);
      if (instr_valid && !fetch_stall && !is_branch && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_vec("instr_pc", instr_pc, e[31:0]);
         check_vec("instr", instr, e[31:0]);
         check_vec("instr_err", {31'b0, instr_err}, {31'b0, e[32]});
         if (gap_en && last_ret >= 0) check_vec("gap", cyc - last_ret, 32'd1);
         last_ret = cyc;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst         = 1'b0;
      ARREADY     = 1'b0;
      RVALID      = 1'b0;
      RDATA       = '0;
      RRESP       = '0;
      fetch_stall = 1'b0;
      is_branch   = 1'b0;
      new_pc      = '0;
      rsp_addr_q.delete();
      rsp_due_q.delete();
      exp_q.delete();
      tb_out   = 0;
      ar_total = 0;
      ar_wait  = 0;
      hold_v   = 1'b0;
      stab_en  = 1'b0;
      ar_chk_n = 0;
      ar_skip  = 0;
      br_mode  = 0;
      br_done  = 1'b0;
      gap_en   = 1'b0;
      last_ret = -1;
      err_en   = 1'b0;
      lat      = 1;
      ar_delay = 0;
      #1;
      check_vec("rst_arvalid", {31'b0, ARVALID}, 32'd0);
      check_vec("rst_araddr", ARADDR, 32'h0);
      check_vec("rst_rready", {31'b0, RREADY}, 32'd1);
      check_vec("rst_instr", instr, 32'h0000_0013);
      check_vec("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
      check_vec("rst_instr_pc", instr_pc, 32'h0);
      check_vec("rst_instr_err", {31'b0, instr_err}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_until_drained(input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         tick();
         n++;
      end
      if (exp_q.size() > 0) check_vec("drain_timeout", exp_q.size(), 32'd0);
   endtask

   task automatic wait_branch(input int budget);
      int n;
      n = 0;
      while (!br_done && n < budget) begin
         tick();
         n++;
      end
      check_vec("branch_fired", {31'b0, br_done}, 32'd1);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      rst         = 1'b0;
      fetch_stall = 1'b0;
      is_branch   = 1'b0;
      new_pc      = '0;
      ARREADY     = 1'b0;
      RVALID      = 1'b0;
      RDATA       = '0;
      RRESP       = '0;
      err_addr    = '0;
      hold_a      = '0;
      ar_exp      = '0;
      br_target   = '0;
      br_expect   = '0;
      @(negedge clk);

      // Streaming with a 1-cycle memory: addresses and instructions 0,4,8.. one per cycle
      do_reset();
      for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 32'(i * 4)});
      ar_exp   = 32'h0;
      ar_chk_n = 16;
      gap_en   = 1'b1;
      run_until_drained(100);

      // Decode stalled: queue fills to four, AR stops, head stays at 0
      do_reset();
      fetch_stall = 1'b1;
      repeat (10) begin
         tick();
         if (instr_valid) check_vec("stall_head", instr_pc, 32'h0);
      end
      check_vec("stall_arvalid", {31'b0, ARVALID}, 32'd0);
      check_vec("stall_ar_total", ar_total, 32'd4);
      check_vec("stall_in_flight", tb_out, 32'd0);
      check_vec("stall_valid", {31'b0, instr_valid}, 32'd1);
      fetch_stall = 1'b0;
      for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, 32'(i * 4)});
      run_until_drained(100);

      // Slow ARREADY: address held stable while waiting
      do_reset();
      ar_delay = 3;
      stab_en  = 1'b1;
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 32'(i * 4)});
      ar_exp   = 32'h0;
      ar_chk_n = 8;
      run_until_drained(200);
      stab_en = 1'b0;

      // Latency 3, two reads in flight, redirect to 0x103
      do_reset();
      lat         = 3;
      fetch_stall = 1'b1;
      br_mode     = 1;
      br_target   = 32'h0000_0103;
      br_expect   = 32'h0000_0100;
      wait_branch(50);
      fetch_stall = 1'b0;
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 32'h100 + 32'(i * 4)});
      run_until_drained(200);
      check_vec("t4_ar_checked", ar_chk_n, 32'd0);

      // Redirect in the same cycle as an R handshake with an AR still pending
      do_reset();
      ar_delay  = 2;
      br_mode   = 2;
      br_target = 32'h0000_0202;
      br_expect = 32'h0000_0200;
      for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 32'h200 + 32'(i * 4)});
      wait_branch(50);
      run_until_drained(200);
      check_vec("t5_ar_checked", ar_chk_n, 32'd0);

      // Error response on 0x8, then reset in the middle of the stream
      do_reset();
      err_en   = 1'b1;
      err_addr = 32'h8;
      exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b0, 32'h4});
      exp_q.push_back({1'b1, 32'h8});
      exp_q.push_back({1'b0, 32'hC});
      exp_q.push_back({1'b0, 32'h10});
      run_until_drained(100);
      check_vec("burst_active", {31'b0, instr_valid}, 32'd1);
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
